// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the instruction-fetch (I) side
//            and the data-access (D) side. One request is latched, run on the
//            memory port to completion, and its response is returned to the
//            side that owns it. D normally wins contention, but only for
//            MAX_D_RUN consecutive grants while I is waiting.
// Ports    : clk, reset_n (async, active-low)
//            i_read/i_addr  -> i_rdata/i_resp                 (I side)
//            d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp  (D side)
//            mem_read/mem_write/mem_addr/mem_wdata -> memory
//            mem_rdata/mem_resp <- memory
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [3:0] C_MAX_RUN = 4'(MAX_D_RUN);

    state_e              state_q, state_d;
    logic [3:0]          d_run_q, d_run_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;

    logic w_d_req;
    logic w_serve_i;
    logic w_serve_d;

    assign w_d_req   = d_read | d_write;
    assign w_serve_i = (state_q == ST_SERVE_I);
    assign w_serve_d = (state_q == ST_SERVE_D);

    always_comb begin
        state_d = state_q;
        d_run_d = d_run_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE: begin
                // I wins when alone, or when D has used up its run budget.
                if (i_read && (!w_d_req || (d_run_q >= C_MAX_RUN))) begin
                    state_d = ST_SERVE_I;
                    addr_d  = i_addr;
                    write_d = 1'b0;
                    d_run_d = 4'd0;
                end else if (w_d_req) begin
                    state_d = ST_SERVE_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    // A simultaneous read+write is a write.
                    write_d = d_write;
                    // Only D grants that bypass a waiting I count toward the run.
                    if (!i_read) begin
                        d_run_d = 4'd0;
                    end else if (d_run_q < C_MAX_RUN) begin
                        d_run_d = d_run_q + 4'd1;
                    end
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (mem_resp) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Bubble cycle: lets the requester drop its level request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            d_run_q <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_run_q <= d_run_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Commands drop in the same cycle as mem_resp so the memory never sees
    // a command that looks like a fresh request after completion.
    assign mem_read  = (w_serve_i | (w_serve_d & ~write_q)) & ~mem_resp;
    assign mem_write = w_serve_d & write_q & ~mem_resp;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Responses are routed to the owner only; mem_resp outside SERVE is ignored.
    assign i_resp  = w_serve_i & mem_resp;
    assign d_resp  = w_serve_d & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule
`default_nettype wire
